// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code sequence player.
package code_seq_pkg;

    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 16;
    localparam int RESET_LEN = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    // Power-on table contents: 2,1,5,5,0,0,7,9,4 at addresses 0..8, zero above.
    function automatic logic [7:0] reset_code(input int unsigned addr);
        logic [7:0] code;
        case (addr)
            0:       code = 8'd2;
            1:       code = 8'd1;
            2:       code = 8'd5;
            3:       code = 8'd5;
            4:       code = 8'd0;
            5:       code = 8'd0;
            6:       code = 8'd7;
            7:       code = 8'd9;
            8:       code = 8'd4;
            default: code = 8'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/code_seq_table.sv
// Code table: register file with reset initialisation, one write port and
// one combinational read port.
module code_seq_table
    import code_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Reload the default codes on reset, otherwise commit accepted writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DW'(reset_code(i));
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational, so a same-cycle write is not yet visible.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/code_seq_player.sv
// Table-driven digit sequence player: steps through the code table forward
// or reverse, with skip-to-terminal, looping and a done pulse.
//
// Output semantics: valid=1 means sal/idx hold a live table entry of the
// current sequence. done and wr_err are single-cycle pulses, registered,
// appearing the cycle after the step or rejected write that caused them.
module code_seq_player
    import code_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          step_en,
    input  logic          dir,
    input  logic          skip,
    input  logic          loop_en,
    input  logic [AW:0]   len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] sal,
    output logic [AW-1:0] idx,
    output logic          valid,
    output logic          done,
    output logic          wr_err,
    output logic [1:0]    dbg_state
);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] sal_q, sal_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          wr_err_q, wr_err_d;

    logic [AW:0]   len_eff;
    logic [AW-1:0] st_last, st_first;
    logic [AW-1:0] last_idx, first_idx, term_idx;
    logic          idle_like;
    logic          wr_ok;
    logic [DW-1:0] rd_data;

    // Table reads follow the next index so sal can register the new entry.
    code_seq_table #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_ok),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_d),
        .rdata_o (rd_data)
    );

    // Length clamp for start, and first/terminal indices of the live sequence.
    always_comb begin
        if (len == '0) begin
            len_eff = (AW+1)'(1);
        end else if (len > (AW+1)'(DEPTH)) begin
            len_eff = (AW+1)'(DEPTH);
        end else begin
            len_eff = len;
        end
        st_last   = AW'(len_eff - (AW+1)'(1));
        st_first  = dir ? st_last : '0;
        last_idx  = AW'(len_q - (AW+1)'(1));
        first_idx = dir_q ? last_idx : '0;
        term_idx  = dir_q ? '0 : last_idx;
        idle_like = (state_q == ST_IDLE) || (state_q == ST_STOP);
        wr_ok     = wr_en && idle_like && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
    end

    // Next-state and datapath decisions; abort outranks every other request.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        dir_d    = dir_q;
        idx_d    = idx_q;
        sal_d    = sal_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        wr_err_d = wr_en && !wr_ok;

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            sal_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_STOP: begin
                    if (start) begin
                        len_d   = len_eff;
                        dir_d   = dir;
                        idx_d   = st_first;
                        sal_d   = rd_data;
                        valid_d = 1'b1;
                        state_d = (len_eff == (AW+1)'(1)) ? ST_LAST : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (skip) begin
                        idx_d   = term_idx;
                        sal_d   = rd_data;
                        state_d = ST_LAST;
                    end else if (step_en) begin
                        idx_d   = dir_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
                        sal_d   = rd_data;
                        state_d = (idx_d == term_idx) ? ST_LAST : ST_RUN;
                    end
                end
                ST_LAST: begin
                    if (step_en || skip) begin
                        done_d = 1'b1;
                        if (loop_en) begin
                            idx_d   = first_idx;
                            sal_d   = rd_data;
                            state_d = (len_q == (AW+1)'(1)) ? ST_LAST : ST_RUN;
                        end else begin
                            valid_d = 1'b0;
                            state_d = ST_STOP;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= (AW+1)'(1);
            dir_q    <= 1'b0;
            idx_q    <= '0;
            sal_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            dir_q    <= dir_d;
            idx_q    <= idx_d;
            sal_q    <= sal_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign sal       = sal_q;
    assign idx       = idx_q;
    assign valid     = valid_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/code_seq_player.md
Name: code_seq_player

Overview:
- Parametrised, table-driven digit-sequence player.
- Steps through a writable code table of up to DEPTH entries, forward or reverse, one entry per step request.
- Supports skip-to-terminal, single-shot or looping playback, and a done pulse on sequence completion.
- Drives the digit/display path; the table is loaded by the control block while the player is idle.

Parameters:
- DW, 4, width of each code entry and of sal.
- DEPTH, 16, number of table entries (must be ≥ 9).
- AW, $clog2(DEPTH), table address width (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin playback (honoured only in IDLE or STOP).
- abort  in  1  return to IDLE from any state.
- step_en  in  1  advance one entry.
- dir  in  1  0 = forward (index 0 upward), 1 = reverse; sampled at start.
- skip  in  1  jump immediately to the terminal entry.
- loop_en  in  1  1 = restart after terminal; sampled at each terminal step.
- len  in  AW+1  sequence length; sampled at start.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  DW  table write data.
- sal  out  DW  current code entry (registered).
- idx  out  AW  current table index (registered).
- valid  out  1  sal holds a live entry.
- done  out  1  one-cycle pulse when the terminal entry is stepped past.
- wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - state = IDLE; sal = 0, idx = 0, valid = 0, done = 0, wr_err = 0.
  - Table reinitialised to 2,1,5,5,0,0,7,9,4 at addresses 0..8; all remaining addresses = 0.
  - rst overrides every other input.
- States: IDLE, RUN, LAST, STOP.
- Length sampling at start: len_q = len, with len = 0 forced to 1 and len > DEPTH clamped to DEPTH. dir_q = dir is captured in the same cycle.
- Derived indices:
  - first = 0 (forward) or len_q−1 (reverse).
  - term = len_q−1 (forward) or 0 (reverse).
- IDLE / STOP, on start:
  - idx ← first; sal ← table[first]; valid ← 1; latency 1 cycle.
  - Next state is RUN, or LAST if len_q = 1.
- STOP: valid = 0; sal holds the last value.
- RUN:
  - skip (wins over step_en): idx ← term, sal ← table[term], next state LAST.
  - Otherwise step_en: idx ← idx+1 (forward) or idx−1 (reverse) and sal ← table[new idx]. Next state is LAST if new idx = term, else RUN.
  - Neither asserted: hold.
- LAST:
  - On step_en or skip: done = 1 for exactly one cycle.
  - If loop_en: idx ← first, sal ← table[first], next state RUN (LAST if len_q = 1), valid stays 1.
  - Otherwise next state STOP, valid ← 0.
- start outside IDLE/STOP is ignored.
- abort (any state, lower priority than rst only): next state IDLE, valid ← 0, sal ← 0, idx ← 0. No done pulse. abort beats start, skip and step_en in the same cycle.
- Writes:
  - Accepted only in IDLE or STOP: table[wr_addr] ← wr_data, visible from the next cycle.
  - If wr_addr ≥ DEPTH, or the state is RUN/LAST, the write is dropped and wr_err pulses for 1 cycle.
  - A write and start in the same cycle: the write is committed and start reads the old contents at first.
- Table reads are combinational from registers; sal is always registered.
- No wrap arithmetic reaches outside 0..len_q−1.

Decomposition:
- Shared package code_seq_pkg holds:
  - the state enum (IDLE, RUN, LAST, STOP);
  - the reset-table constant array (2,1,5,5,0,0,7,9,4);
  - the DW and DEPTH defaults.
- One sub-module, code_seq_table: register file with reset init, one write port and one combinational read port.
- The FSM and index logic stay in code_seq_player.

Test Plan:
1. Reset, then start with len = 9, dir = 0, loop_en = 0, and 9 step_en pulses:
   - sal = 2,1,5,5,0,0,7,9,4;
   - done pulses on the 9th step;
   - state STOP, valid = 0.
2. Reverse playback: start with len = 9, dir = 1, then 8 steps:
   - sal = 4,9,7,0,0,5,5,1,2;
   - the next step gives done, and with loop_en = 1 sal returns to 4, valid stays 1.
3. Skip: start forward with len = 9, two steps (sal = 5), then skip + step_en in the same cycle:
   - sal = 4, idx = 8, state LAST;
   - the next step pulses done.
4. Writes:
   - in IDLE, write addr 3 ← 0xA, then start forward: the 4th entry is A;
   - a write during RUN pulses wr_err and leaves the table unchanged.
5. Length boundaries:
   - len = 0: start gives sal = 2, state LAST, and one step gives done;
   - len = 20 (DEPTH = 16): clamped, idx runs 0..15.
6. Abort and reset mid-run:
   - abort at idx = 4 gives valid = 0, sal = 0, IDLE, no done;
   - rst at idx = 5 after table writes restores the default table and outputs.
